// File: rtl/bdi_mem_pkg.sv
// bdi_mem_pkg: shared defaults, state encoding and width helpers for the line port
package bdi_mem_pkg;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_WORDS_PER_LINE = 8;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, RESP} mlp_state_e;
  function automatic int ofs_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int line_width(input int w, input int n);
    return w * n;
  endfunction
endpackage

// File: rtl/line_word_buffer.sv
// line_word_buffer: line register with whole-line load, word-indexed write and word-indexed read
module line_word_buffer
  import bdi_mem_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int LINE_WIDTH = line_width(WORD_WIDTH, WORDS_PER_LINE),
  localparam int OFS_W = ofs_w(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] load_line,
  input  logic                  we,
  input  logic [OFS_W-1:0]      widx,
  input  logic [WORD_WIDTH-1:0] wword,
  input  logic [OFS_W-1:0]      ridx,
  output logic [WORD_WIDTH-1:0] rword,
  output logic [LINE_WIDTH-1:0] line_next
);
  logic [LINE_WIDTH-1:0] line;
  // next line contents: optional full load, then the single-word write on top
  always_comb begin
    line_next = load ? load_line : line;
    if (we) line_next[widx*WORD_WIDTH +: WORD_WIDTH] = wword;
  end
  assign rword = line[ridx*WORD_WIDTH +: WORD_WIDTH];
  // line storage
  always_ff @(posedge clk) line <= rst ? '0 : line_next;
endmodule

// File: rtl/mem_line_port.sv
// mem_line_port: turns one cache-line request into a burst of single-word memory accesses
module mem_line_port
  import bdi_mem_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int LINE_WIDTH = line_width(WORD_WIDTH, WORDS_PER_LINE),
  localparam int OFS_W = ofs_w(WORDS_PER_LINE),
  localparam int LADDR_W = ADDR_WIDTH - 2 - OFS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [LADDR_W-1:0]    req_line_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [LINE_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-3:0] mem_read_addr,
  output logic                  mem_read_addr_valid,
  input  logic                  mem_read_ready,
  input  logic [WORD_WIDTH-1:0] mem_read_data,
  input  logic                  mem_read_valid,
  output logic [WORD_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-3:0] mem_write_addr,
  output logic                  mem_write_en
);
  mlp_state_e state;
  logic [LADDR_W-1:0] line_addr;
  logic [OFS_W:0] cnt;
  logic [OFS_W-1:0] nidx;
  logic last, accept, capture;
  logic [WORD_WIDTH-1:0] rword;
  logic [LINE_WIDTH-1:0] line_next;
  assign nidx = cnt[OFS_W-1:0] + OFS_W'(1);
  assign last = cnt == (OFS_W+1)'(WORDS_PER_LINE - 1);
  assign accept = state == IDLE && req_valid;
  assign capture = state == RD_WAIT && mem_read_valid;
  line_word_buffer #(.WORD_WIDTH(WORD_WIDTH), .WORDS_PER_LINE(WORDS_PER_LINE)) u_buf (
    .clk(clk), .rst(rst),
    .load(accept && req_write), .load_line(req_wdata),
    .we(capture), .widx(cnt[OFS_W-1:0]), .wword(mem_read_data),
    .ridx(nidx), .rword(rword), .line_next(line_next)
  );
  // control FSM; every memory-side output is issued one word ahead from registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      mem_read_addr_valid <= 1'b0;
      mem_read_addr <= '0;
      mem_write_en <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      line_addr <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          line_addr <= req_line_addr;
          cnt <= '0;
          req_ready <= 1'b0;
          state <= req_write ? WR : RD_REQ;
          if (req_write) begin
            mem_write_en <= 1'b1;
            mem_write_addr <= {req_line_addr, {OFS_W{1'b0}}};
            mem_write_data <= req_wdata[WORD_WIDTH-1:0];
          end else begin
            mem_read_addr_valid <= 1'b1;
            mem_read_addr <= {req_line_addr, {OFS_W{1'b0}}};
          end
        end
        RD_REQ: if (mem_read_ready) begin
          mem_read_addr_valid <= 1'b0;
          state <= RD_WAIT;
        end
        RD_WAIT: if (mem_read_valid) begin
          if (last) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_write <= 1'b0;
            resp_rdata <= line_next;
          end else begin
            cnt <= cnt + 1'b1;
            mem_read_addr_valid <= 1'b1;
            mem_read_addr <= {line_addr, nidx};
            state <= RD_REQ;
          end
        end
        WR: if (last) begin
          mem_write_en <= 1'b0;
          state <= RESP;
          resp_valid <= 1'b1;
          resp_write <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          mem_write_addr <= {line_addr, nidx};
          mem_write_data <= rword;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
